fp32_mul_front_end: RTL and testbench
=====================================

Name: fp32_mul_front_end

Overview:
- Registered front-end stage of the single-precision (IEEE-754 binary32) multiplier.
- Splits both operands into fields and restores the hidden bits. Produces the result sign and the exception/zero flags.
- Computes the 9-bit biased result exponent, including the normalisation increment.
- Feeds the downstream significand-rounding, flow-detection and result-assembly logic one cycle later.

Parameters:
- BIAS, 127, exponent bias subtracted when adding the operand exponents.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands a/b are valid this cycle
- a  in  32  operand A, binary32
- b  in  32  operand B, binary32
- out_valid  out  1  registered outputs are valid
- sign  out  1  result sign
- exception  out  1  either operand has exponent 8'hFF (Inf/NaN)
- zero  out  1  either operand has exponent 8'h00 and no exception is flagged
- normalised  out  1  significand product bit 47 (product ≥ 2.0)
- exponent  out  9  biased result exponent, 9-bit wrap
- significand_a  out  24  {hidden_a, a[22:0]}
- significand_b  out  24  {hidden_b, b[22:0]}

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Reset: while rst_n=0 at a rising edge, all outputs clear to 0, including out_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- out_valid = in_valid registered.
- Data outputs load every cycle, regardless of in_valid. There is no stall or backpressure.
- Decompose, per operand:
  - s = bit31
  - e = bits30:23
  - hidden = OR-reduce(e), so subnormal and zero operands get hidden = 0
  - significand = {hidden, bits22:0}
- sign = s_a XOR s_b. This holds for zero, Inf and NaN operands as well.
- exception = (e_a==8'hFF) OR (e_b==8'hFF).
- zero = NOT exception AND ((e_a==0) OR (e_b==0)). Exception takes priority over zero.
- normalised = bit 47 of the unsigned 48-bit product significand_a × significand_b.
  - Only the MSB is needed; implementations may compute the full product or a dedicated MSB compare.
- exponent = ({1'b0,e_a} + {1'b0,e_b} − BIAS + normalised), taken modulo 512, as a 9-bit unsigned value.
  - Negative intermediate results wrap. Example: 0 + 0 − 127 = 9'h181.
  - Downstream logic interprets exponent[8:7] for overflow/underflow. This block does no saturation.
- The exponent is computed even when exception or zero is set; the flags do not gate it.
- NaN payloads are not inspected. NaN is treated like Inf (exception only).
- Reset asserted mid-stream: the next edge clears the outputs. The data from that cycle is lost.

Test Plan:
- a=4234_851F, b=427C_851F (45.13×63.13): one cycle later sign=0, exception=0, zero=0, normalised=1, exponent=9'h08A, significand_a=B4851F.
- a=4049_999A, b=C166_3D71 (3.15×−14.39) -> sign=1, normalised=1, exponent=9'h084, exception=0, zero=0.
- a=4580_0000, b=4580_0000 (4096²) -> normalised=0, exponent=9'h097, sign=0. Also a=3ACA_62C1 squared -> normalised=1, exponent=9'h06C.
- a=0000_0000, b=0000_0000 -> zero=1, exception=0, exponent=9'h181, significands=0.
- a=C152_6666, b=0000_0000 -> sign=1, zero=1, exponent=9'h003, normalised=0.
- a=b=7F80_0000 (Inf×Inf) -> exception=1, zero=0, sign=0, exponent=9'h17F.
- Reset: hold rst_n=0 with in_valid=1 -> all outputs 0. Release rst_n and drive two back-to-back operand pairs -> out_valid high on consecutive cycles with matching results.

Source files
------------

// File: rtl/fp32_mul_front_end_if.sv
// Operand/result bundle for the binary32 multiplier front-end stage.
// The master supplies operands and observes the decomposed result fields.
interface fp32_mul_front_end_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;

    logic        out_valid;
    logic        sign;
    logic        exception;
    logic        zero;
    logic        normalised;
    logic [8:0]  exponent;
    logic [23:0] significand_a;
    logic [23:0] significand_b;

    modport master (
        output in_valid, a, b,
        input  out_valid, sign, exception, zero, normalised,
               exponent, significand_a, significand_b
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, sign, exception, zero, normalised,
               exponent, significand_a, significand_b
    );
endinterface

// File: rtl/fp32_mul_front_end.sv
// Registered front-end of the binary32 multiplier: field split, hidden-bit restore,
// sign/exception/zero flags and the normalisation-adjusted 9-bit biased exponent.
module fp32_mul_front_end #(
    parameter int BIAS = 127
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp32_mul_front_end_if.slave   bus
);

    logic        w_sign_a, w_sign_b;
    logic [7:0]  w_exp_a, w_exp_b;
    logic        w_hidden_a, w_hidden_b;
    logic [23:0] w_sig_a, w_sig_b;
    logic [47:0] w_product;
    logic        w_exception;
    logic        w_zero;
    logic        w_normalised;
    logic [8:0]  w_exponent;

    logic        r_out_valid;
    logic        r_sign;
    logic        r_exception;
    logic        r_zero;
    logic        r_normalised;
    logic [8:0]  r_exponent;
    logic [23:0] r_sig_a, r_sig_b;

    assign w_sign_a   = bus.a[31];
    assign w_sign_b   = bus.b[31];
    assign w_exp_a    = bus.a[30:23];
    assign w_exp_b    = bus.b[30:23];
    assign w_hidden_a = |w_exp_a;
    assign w_hidden_b = |w_exp_b;
    assign w_sig_a    = {w_hidden_a, bus.a[22:0]};
    assign w_sig_b    = {w_hidden_b, bus.b[22:0]};

    // Only the product MSB is consumed here; the full product lets synthesis prune the rest.
    assign w_product    = w_sig_a * w_sig_b;
    assign w_normalised = w_product[47];

    assign w_exception = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);
    assign w_zero      = !w_exception && ((w_exp_a == 8'h00) || (w_exp_b == 8'h00));

    // Modulo-512 arithmetic: underflow wraps into the top range, read downstream via bits [8:7].
    assign w_exponent = {1'b0, w_exp_a} + {1'b0, w_exp_b} - 9'(BIAS) + {8'b0, w_normalised};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_sign       <= 1'b0;
            r_exception  <= 1'b0;
            r_zero       <= 1'b0;
            r_normalised <= 1'b0;
            r_exponent   <= 9'd0;
            r_sig_a      <= 24'd0;
            r_sig_b      <= 24'd0;
        end else begin
            r_out_valid  <= bus.in_valid;
            r_sign       <= w_sign_a ^ w_sign_b;
            r_exception  <= w_exception;
            r_zero       <= w_zero;
            r_normalised <= w_normalised;
            r_exponent   <= w_exponent;
            r_sig_a      <= w_sig_a;
            r_sig_b      <= w_sig_b;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.sign          = r_sign;
    assign bus.exception     = r_exception;
    assign bus.zero          = r_zero;
    assign bus.normalised    = r_normalised;
    assign bus.exponent      = r_exponent;
    assign bus.significand_a = r_sig_a;
    assign bus.significand_b = r_sig_b;

endmodule

// File: tb/tb_fp32_mul_front_end.sv
// Directed-vector bench for fp32_mul_front_end; expected fields are hand-derived
// from the binary32 encodings of each operand pair.
module tb_fp32_mul_front_end;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp32_mul_front_end_if bus ();

    fp32_mul_front_end #(.BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic s,
                             input logic ex, input logic z, input logic n,
                             input logic [8:0] e, input logic [23:0] sa,
                             input logic [23:0] sb);
        check({tag, ".out_valid"},  48'(bus.out_valid),     48'(ov));
        check({tag, ".sign"},       48'(bus.sign),          48'(s));
        check({tag, ".exception"},  48'(bus.exception),     48'(ex));
        check({tag, ".zero"},       48'(bus.zero),          48'(z));
        check({tag, ".normalised"}, 48'(bus.normalised),    48'(n));
        check({tag, ".exponent"},   48'(bus.exponent),      48'(e));
        check({tag, ".sig_a"},      48'(bus.significand_a), 48'(sa));
        check({tag, ".sig_b"},      48'(bus.significand_b), 48'(sb));
    endtask

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'h4234_851F;
        bus.b        = 32'h427C_851F;

        // Reset held with valid operands present: everything stays cleared.
        step(1'b1, 32'h4234_851F, 32'h427C_851F);
        step(1'b1, 32'hFF80_0000, 32'h7F80_0000);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 24'h0, 24'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // 45.13 x 63.13 followed back-to-back by 3.15 x -14.39.
        step(1'b1, 32'h4234_851F, 32'h427C_851F);
        check_all("v45x63", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h08A, 24'hB4851F, 24'hFC851F);
        step(1'b1, 32'h4049_999A, 32'hC166_3D71);
        check_all("v3x-14", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h084, 24'hC9999A, 24'hE63D71);

        // Exact power of two squared: product 1.0, no normalisation increment.
        step(1'b1, 32'h4580_0000, 32'h4580_0000);
        check_all("v4096sq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h097, 24'h800000, 24'h800000);
        step(1'b1, 32'h3ACA_62C1, 32'h3ACA_62C1);
        check_all("vsmallsq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h06C, 24'hCA62C1, 24'hCA62C1);

        // Zero operands: exponent wraps below zero.
        step(1'b1, 32'h0000_0000, 32'h0000_0000);
        check_all("vzero", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h181, 24'h0, 24'h0);
        step(1'b1, 32'hC152_6666, 32'h0000_0000);
        check_all("vnegxzero", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h003, 24'hD26666, 24'h0);

        // Subnormal operand: hidden bit stays clear, zero flag set.
        step(1'b1, 32'h0040_0000, 32'h3F80_0000);
        check_all("vsubnorm", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 24'h400000, 24'h800000);

        // Inf/NaN: exception wins over zero; exponent still computed.
        step(1'b1, 32'h7F80_0000, 32'h7F80_0000);
        check_all("vinfxinf", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h17F, 24'h800000, 24'h800000);
        step(1'b1, 32'h7FC0_0000, 32'h0000_0000);
        check_all("vnanxzero", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h080, 24'hC00000, 24'h0);
        step(1'b1, 32'hFF80_0000, 32'h3F80_0000);
        check_all("vninfx1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0FF, 24'h800000, 24'h800000);

        // Idle cycle: out_valid drops but data still loads.
        step(1'b0, 32'h4049_999A, 32'hC166_3D71);
        check_all("vidle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h084, 24'hC9999A, 24'hE63D71);

        // Mid-stream reset discards the operands present on that edge.
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b1, 32'h4234_851F, 32'h427C_851F);
        check_all("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 24'h0, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hC152_6666, 32'h0000_0000);
        check_all("postreset", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h003, 24'hD26666, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
